// File: rtl/icon_pkg.sv
// Shared types and defaults for the bot icon update scheduler.
// Octant codes run clockwise from north; locations are in 4-pixel icon units.
package icon_pkg;

    typedef enum logic [2:0] {
        OCT_N  = 3'd0,
        OCT_NE = 3'd1,
        OCT_E  = 3'd2,
        OCT_SE = 3'd3,
        OCT_S  = 3'd4,
        OCT_SW = 3'd5,
        OCT_W  = 3'd6,
        OCT_NW = 3'd7
    } octant_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    localparam int ICON_H_ACTIVE     = 640;
    localparam int ICON_V_ACTIVE     = 480;
    localparam int ICON_LOC_MIN      = 2;
    localparam int ICON_LOCX_MAX     = 158;
    localparam int ICON_LOCY_MAX     = 118;
    localparam int ICON_STALE_FRAMES = 60;
    localparam int ICON_BLINK_FRAMES = 16;

    localparam logic [7:0] LOCX_RESET = 8'd80;
    localparam logic [7:0] LOCY_RESET = 8'd60;

    function automatic logic [7:0] clamp_loc(input logic [7:0] val,
                                             input logic [7:0] lo,
                                             input logic [7:0] hi);
        if (val < lo)
            return lo;
        else if (val > hi)
            return hi;
        else
            return val;
    endfunction

endpackage

// File: rtl/orie_stepper.sv
// Next displayed octant: one step toward the target along the shorter way round,
// with the half-turn tie going clockwise.
module orie_stepper (
    input  logic [2:0] cur,
    input  logic [2:0] target,
    output logic [2:0] orie_next
);

    logic [2:0] diff;

    always_comb begin
        diff = target - cur;
        if (diff == 3'd0)
            orie_next = cur;
        else if (diff <= 3'd4)
            orie_next = cur + 3'd1;
        else
            orie_next = cur - 3'd1;
    end

endmodule

// File: rtl/icon_ctrl.sv
// Bot icon update scheduler: buffers position/orientation updates and commits them
// at the start of vertical blank, steps orientation per frame and blinks when stale.
module icon_ctrl
    import icon_pkg::*;
#(
    parameter int H_ACTIVE     = ICON_H_ACTIVE,
    parameter int V_ACTIVE     = ICON_V_ACTIVE,
    parameter int LOC_MIN      = ICON_LOC_MIN,
    parameter int LOCX_MAX     = ICON_LOCX_MAX,
    parameter int LOCY_MAX     = ICON_LOCY_MAX,
    parameter int STALE_FRAMES = ICON_STALE_FRAMES,
    parameter int BLINK_FRAMES = ICON_BLINK_FRAMES
)(
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] vert,
    input  logic [9:0] horz,
    input  logic       upd_valid,
    input  logic [7:0] upd_LocX,
    input  logic [7:0] upd_LocY,
    input  logic [2:0] upd_Orie,
    output logic       upd_ready,
    output logic [7:0] bot_LocX,
    output logic [7:0] bot_LocY,
    output logic [2:0] bot_Orie,
    output logic       icon_en,
    output logic       frame_tick
);

    // An oversized max is pulled back so the 8-pixel icon margin always stays on screen.
    localparam int LOCX_HI = (LOCX_MAX * 4 + 8 <= H_ACTIVE) ? LOCX_MAX : (H_ACTIVE - 8) / 4;
    localparam int LOCY_HI = (LOCY_MAX * 4 + 8 <= V_ACTIVE) ? LOCY_MAX : (V_ACTIVE - 8) / 4;
    localparam int STALE_W = $clog2(STALE_FRAMES + 1);
    localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic               commit;
    logic               blank_start;
    logic [7:0]         shadow_locx;
    logic [7:0]         shadow_locy;
    logic [2:0]         shadow_orie;
    logic [2:0]         target_orie;
    logic [2:0]         orie_step;
    logic [STALE_W-1:0] stale_cnt;
    logic [BLINK_W-1:0] blink_cnt;

    assign accept      = upd_valid && upd_ready;
    assign blank_start = (vert == 10'(V_ACTIVE)) && (horz == 10'd0);

    orie_stepper u_orie_stepper (
        .cur       (bot_Orie),
        .target    (target_orie),
        .orie_next (orie_step)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (accept) state_next = ST_PENDING;
            ST_PENDING: if (frame_tick) state_next = ST_COMMIT;
            ST_COMMIT:  state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        upd_ready = (state != ST_COMMIT);
        commit    = (state == ST_COMMIT);
    end

    always_ff @(posedge clk) begin
        if (reset)
            frame_tick <= 1'b0;
        else
            frame_tick <= blank_start;
    end

    // Last accepted update wins, including one taken in the frame_tick cycle itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_locx <= 8'd0;
            shadow_locy <= 8'd0;
            shadow_orie <= 3'd0;
        end else if (accept) begin
            shadow_locx <= clamp_loc(upd_LocX, 8'(LOC_MIN), 8'(LOCX_HI));
            shadow_locy <= clamp_loc(upd_LocY, 8'(LOC_MIN), 8'(LOCY_HI));
            shadow_orie <= upd_Orie;
        end
    end

    // The step fires one cycle before any commit, so it always sees the previous target.
    always_ff @(posedge clk) begin
        if (reset) begin
            bot_LocX    <= LOCX_RESET;
            bot_LocY    <= LOCY_RESET;
            bot_Orie    <= OCT_N;
            target_orie <= OCT_N;
        end else begin
            if (commit) begin
                bot_LocX    <= shadow_locx;
                bot_LocY    <= shadow_locy;
                target_orie <= shadow_orie;
            end
            if (frame_tick)
                bot_Orie <= orie_step;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || commit) begin
            stale_cnt <= '0;
            blink_cnt <= '0;
            icon_en   <= 1'b1;
        end else if (frame_tick) begin
            if (stale_cnt == STALE_W'(STALE_FRAMES)) begin
                if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
                    blink_cnt <= '0;
                    icon_en   <= ~icon_en;
                end else begin
                    blink_cnt <= blink_cnt + BLINK_W'(1);
                end
            end else begin
                stale_cnt <= stale_cnt + STALE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_icon_ctrl.sv
// Scoreboard bench for icon_ctrl: stimulus queues per-frame expectations, a monitor
// checks them around each frame_tick. Frames are compressed to lines 470..489.
module tb_icon_ctrl;

    typedef struct {
        logic       ready_t2;
        logic [7:0] locx;
        logic [7:0] locy;
        logic [2:0] orie;
        logic       en;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] vert;
    logic [9:0] horz;
    logic       upd_valid;
    logic [7:0] upd_LocX;
    logic [7:0] upd_LocY;
    logic [2:0] upd_Orie;
    logic       upd_ready;
    logic [7:0] bot_LocX;
    logic [7:0] bot_LocY;
    logic [2:0] bot_Orie;
    logic       icon_en;
    logic       frame_tick;

    logic [2:0] st_cur;
    logic [2:0] st_tgt;
    logic [2:0] st_next;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    logic started  = 1'b0;
    logic exp_tick = 1'b0;
    logic prev_ok  = 1'b0;
    logic [22:0] prev_outs;

    icon_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .vert       (vert),
        .horz       (horz),
        .upd_valid  (upd_valid),
        .upd_LocX   (upd_LocX),
        .upd_LocY   (upd_LocY),
        .upd_Orie   (upd_Orie),
        .upd_ready  (upd_ready),
        .bot_LocX   (bot_LocX),
        .bot_LocY   (bot_LocY),
        .bot_Orie   (bot_Orie),
        .icon_en    (icon_en),
        .frame_tick (frame_tick)
    );

    orie_stepper u_step (
        .cur       (st_cur),
        .target    (st_tgt),
        .orie_next (st_next)
    );

    always #5 clk = ~clk;

    // Compressed raster: 4 pixels per line, lines 470..479 visible, 480..489 blank.
    initial begin
        vert = 10'd470;
        horz = 10'd0;
        forever begin
            @(posedge clk);
            #1;
            if (horz == 10'd3) begin
                horz = 10'd0;
                vert = (vert == 10'd489) ? 10'd470 : vert + 10'd1;
            end else begin
                horz = horz + 10'd1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk)
        exp_tick <= !reset && (vert == 10'd480) && (horz == 10'd0);

    // Tick model and scan-window stability, every cycle once running.
    always @(negedge clk) begin
        if (started) begin
            checkOutput("frame_tick", {31'd0, frame_tick}, {31'd0, exp_tick});
            if (prev_ok && vert < 10'd480)
                checkOutput("scan_stable",
                            {9'd0, upd_ready, bot_LocX, bot_LocY, bot_Orie, icon_en, frame_tick},
                            {9'd0, prev_outs});
            prev_outs = {upd_ready, bot_LocX, bot_LocY, bot_Orie, icon_en, frame_tick};
            prev_ok   = 1'b1;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (started && frame_tick === 1'b1) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    @(negedge clk);
                    checkOutput("ready_t2", {31'd0, upd_ready}, {31'd0, e.ready_t2});
                    @(negedge clk);
                    checkOutput("locx_t3", {24'd0, bot_LocX}, {24'd0, e.locx});
                    checkOutput("locy_t3", {24'd0, bot_LocY}, {24'd0, e.locy});
                    checkOutput("orie_t3", {29'd0, bot_Orie}, {29'd0, e.orie});
                    checkOutput("icon_en_t3", {31'd0, icon_en}, {31'd0, e.en});
                end
            end
        end
    end

    task automatic waitLine(input logic [9:0] v);
        int n = 0;
        while (!(vert == v && horz == 10'd0) && n < 400) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 400)
            checkOutput("wait_line_timeout", 32'd0, 32'd1);
    endtask

    task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic [2:0] o);
        int   n = 0;
        logic acc;
        upd_valid = 1'b1;
        upd_LocX  = x;
        upd_LocY  = y;
        upd_Orie  = o;
        do begin
            @(negedge clk);
            acc = upd_ready;
            @(posedge clk);
            #2;
            n++;
        end while (acc !== 1'b1 && n < 50);
        if (acc !== 1'b1)
            checkOutput("accept_timeout", 32'd0, 32'd1);
        upd_valid = 1'b0;
    endtask

    task automatic runFrame(input logic rdy, input logic [7:0] x, input logic [7:0] y,
                            input logic [2:0] o, input logic en);
        exp_t e;
        e.ready_t2 = rdy;
        e.locx     = x;
        e.locy     = y;
        e.orie     = o;
        e.en       = en;
        sb.push_back(e);
        waitLine(10'd480);
        repeat (3) begin
            @(posedge clk);
            #2;
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] p;
        logic [2:0] exp_next;
        int         cw;
        logic       en_exp;

        reset     = 1'b1;
        upd_valid = 1'b0;
        upd_LocX  = 8'd0;
        upd_LocY  = 8'd0;
        upd_Orie  = 3'd0;
        st_cur    = 3'd0;
        st_tgt    = 3'd0;

        waitLine(10'd475);
        @(negedge clk);
        checkOutput("reset_locx", {24'd0, bot_LocX}, 32'd80);
        checkOutput("reset_locy", {24'd0, bot_LocY}, 32'd60);
        checkOutput("reset_orie", {29'd0, bot_Orie}, 32'd0);
        checkOutput("reset_ready", {31'd0, upd_ready}, 32'd1);
        checkOutput("reset_icon_en", {31'd0, icon_en}, 32'd1);
        checkOutput("reset_frame_tick", {31'd0, frame_tick}, 32'd0);
        @(posedge clk);
        #2;
        reset   = 1'b0;
        started = 1'b1;

        // Idle frames
        repeat (3) runFrame(1'b1, 8'd80, 8'd60, 3'd0, 1'b1);

        // Clamp and commit, then two clockwise steps toward E
        waitLine(10'd474);
        applyStimulus(8'd200, 8'd0, 3'd2);
        runFrame(1'b0, 8'd158, 8'd2, 3'd0, 1'b1);
        runFrame(1'b1, 8'd158, 8'd2, 3'd1, 1'b1);
        runFrame(1'b1, 8'd158, 8'd2, 3'd2, 1'b1);
        runFrame(1'b1, 8'd158, 8'd2, 3'd2, 1'b1);

        // Back to north: 2 -> 1 -> 0
        waitLine(10'd474);
        applyStimulus(8'd80, 8'd60, 3'd0);
        runFrame(1'b0, 8'd80, 8'd60, 3'd2, 1'b1);
        runFrame(1'b1, 8'd80, 8'd60, 3'd1, 1'b1);
        runFrame(1'b1, 8'd80, 8'd60, 3'd0, 1'b1);

        // Overwrite within one frame; later S target gives the clockwise tie
        waitLine(10'd474);
        applyStimulus(8'd10, 8'd10, 3'd0);
        applyStimulus(8'd20, 8'd30, 3'd4);
        runFrame(1'b0, 8'd20, 8'd30, 3'd0, 1'b1);

        // Low/high clamp, retarget NW: tie step 0->1 then 1->0->7
        waitLine(10'd474);
        applyStimulus(8'd1, 8'd250, 3'd7);
        runFrame(1'b0, 8'd2, 8'd118, 3'd1, 1'b1);
        runFrame(1'b1, 8'd2, 8'd118, 3'd0, 1'b1);
        runFrame(1'b1, 8'd2, 8'd118, 3'd7, 1'b1);
        runFrame(1'b1, 8'd2, 8'd118, 3'd7, 1'b1);

        // Boundary collision: update held valid across T+1..T+3 while PENDING
        waitLine(10'd474);
        applyStimulus(8'd30, 8'd40, 3'd7);
        sb.push_back('{1'b0, 8'd50, 8'd60, 3'd7, 1'b1});
        waitLine(10'd480);
        @(posedge clk);
        #2;
        upd_valid = 1'b1;
        upd_LocX  = 8'd50;
        upd_LocY  = 8'd60;
        upd_Orie  = 3'd7;
        @(negedge clk);
        checkOutput("coll_ready_t1", {31'd0, upd_ready}, 32'd1);
        @(posedge clk);
        #2;
        @(negedge clk);
        checkOutput("coll_ready_t2", {31'd0, upd_ready}, 32'd0);
        @(posedge clk);
        #2;
        @(negedge clk);
        checkOutput("coll_ready_t3", {31'd0, upd_ready}, 32'd1);
        checkOutput("coll_locx_t3", {24'd0, bot_LocX}, 32'd50);
        @(posedge clk);
        #2;
        upd_valid = 1'b0;
        runFrame(1'b0, 8'd50, 8'd60, 3'd7, 1'b1);

        // Stale: first toggle on frame 76 after the last commit, then every 16
        for (int n = 1; n <= 110; n++) begin
            if (n < 76)
                en_exp = 1'b1;
            else
                en_exp = (((n - 76) / 16) % 2 == 0) ? 1'b0 : 1'b1;
            runFrame(1'b1, 8'd50, 8'd60, 3'd7, en_exp);
        end
        waitLine(10'd474);
        applyStimulus(8'd60, 8'd70, 3'd7);
        runFrame(1'b0, 8'd60, 8'd70, 3'd7, 1'b1);

        // Reset during COMMIT discards the pending update
        waitLine(10'd474);
        applyStimulus(8'd90, 8'd100, 3'd3);
        sb.push_back('{1'b0, 8'd80, 8'd60, 3'd0, 1'b1});
        waitLine(10'd480);
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        #1;
        runFrame(1'b1, 8'd80, 8'd60, 3'd0, 1'b1);

        // Stepper on its own: expected move from the clockwise distance
        for (int c = 0; c < 8; c++) begin
            for (int t = 0; t < 8; t++) begin
                st_cur = 3'(c);
                st_tgt = 3'(t);
                #1;
                p  = st_cur;
                cw = 0;
                while (p != st_tgt) begin
                    p  = p + 3'd1;
                    cw = cw + 1;
                end
                if (cw == 0)
                    exp_next = st_cur;
                else if (cw <= 4)
                    exp_next = st_cur + 3'd1;
                else
                    exp_next = st_cur - 3'd1;
                checkOutput($sformatf("stepper_c%0d_t%0d", c, t), {29'd0, st_next}, {29'd0, exp_next});
            end
        end

        repeat (5) @(posedge clk);
        checkOutput("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
